regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 84 ++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with one-cycle write latency and a pending scoreboard.
// Define REGARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (A wins) otherwise.
module regfile_write_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       a_valid,
  input  logic [2:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [2:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic       rf_enable,
  output logic [2:0] rf_addr,
  output logic [7:0] rf_data,
  input  logic [2:0] rd_addr1,
  input  logic [2:0] rd_addr2,
  output logic       rd_hazard1,
  output logic       rd_hazard2,
  output logic [7:0] pending
);

  logic       open;
  logic       gnt_a, gnt_b, xfer;
  logic [2:0] x_addr;
  logic [7:0] x_data;
  logic [7:0] set_mask, clr_mask;

  // Readies are gated by reset so nothing is accepted in a reset cycle.
  assign open = rst & ~stall;

`ifdef REGARB_ROUND_ROBIN_EN
  logic ptr;  // 0: A preferred, 1: B preferred

  assign a_ready = open & (~ptr | ~b_valid);
  assign b_ready = open & ( ptr | ~a_valid);

  always_ff @(posedge clk) begin
    if (!rst)
      ptr <= 1'b0;
    else if ((gnt_a & ~ptr) | (gnt_b & ptr))
      ptr <= ~ptr;
  end
`else
  assign a_ready = open;
  assign b_ready = open & ~a_valid;
`endif

  assign gnt_a  = a_valid & a_ready;
  assign gnt_b  = b_valid & b_ready;
  assign xfer   = gnt_a | gnt_b;
  assign x_addr = gnt_a ? a_addr : b_addr;
  assign x_data = gnt_a ? a_data : b_data;

  always_comb begin
    set_mask = 8'd0;
    clr_mask = 8'd0;
    if (xfer)      set_mask = 8'd1 << x_addr;
    if (rf_enable) clr_mask = 8'd1 << rf_addr;
  end

  // A same-edge set wins over the clear of the write draining this cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_enable <= 1'b0;
      rf_addr   <= 3'd0;
      rf_data   <= 8'd0;
      pending   <= 8'd0;
    end else begin
      rf_enable <= xfer;
      pending   <= (pending & ~clr_mask) | set_mask;
      if (xfer) begin
        rf_addr <= x_addr;
        rf_data <= x_data;
      end
    end
  end

  assign rd_hazard1 = pending[rd_addr1] | (xfer & (x_addr == rd_addr1));
  assign rd_hazard2 = pending[rd_addr2] | (xfer & (x_addr == rd_addr2));

endmodule
